if_stage: RTL and testbench

Instruction-fetch stage of the five-stage RISC-V pipeline. Owns the program counter and issues one instruction-memory request at a time. Presents the fetched `{pc, inst}` bundle to the decode stage over a valid/allowin handshake. Consumes the branch-redirect bundle produced by decode, flushing wrong-path work including an in-flight memory request.

---
 rtl/if_stage_if.sv | 24 ++
 rtl/if_stage.sv | 82 ++++++++
 tb/tb_if_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage bundle grouping the decode handshake and instruction-memory bus
//   branch_data  {br_taken, br_target} from decode
//   ds_allowin   decode can accept a bundle
//   fs_valid/fs_data  {pc, inst} bundle to decode
//   inst_req/inst_addr/inst_addr_ok/inst_data_ok/inst_rdata  instruction-memory port
interface if_stage_if;
    logic [32:0] branch_data;
    logic        ds_allowin;
    logic        fs_valid;
    logic [63:0] fs_data;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    modport master (
        input  branch_data, ds_allowin, inst_addr_ok, inst_data_ok, inst_rdata,
        output fs_valid, fs_data, inst_req, inst_addr
    );
    modport slave (
        output branch_data, ds_allowin, inst_addr_ok, inst_data_ok, inst_rdata,
        input  fs_valid, fs_data, inst_req, inst_addr
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch, one outstanding memory request, redirect flushes wrong-path work
//   clk, reset  rising-edge clock, synchronous active-high reset
//   bus         if_stage_if.master: decode handshake, branch redirect, instruction-memory port
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input logic       clk,
    input logic       reset,
    if_stage_if.master bus
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
    state_t      state, state_n;
    logic [31:0] pc, pc_n, req_pc, fs_pc, fs_inst;
    logic        cancel, cancel_n, load;
    logic        br_taken;
    logic [31:0] br_target;
    logic        unused_lsb;
    assign br_taken   = bus.branch_data[32];
    assign br_target  = {bus.branch_data[31:2], 2'b00};
    assign unused_lsb = ^bus.branch_data[1:0];
    assign bus.inst_req  = (state == S_REQ) & ~reset;
    assign bus.inst_addr = pc;
    // a redirect kills the held bundle in the same cycle it arrives
    assign bus.fs_valid  = (state == S_HOLD) & ~br_taken & ~reset;
    assign bus.fs_data   = {fs_pc, fs_inst};
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        cancel_n = cancel;
        load     = 1'b0;
        case (state)
            S_REQ: begin
                if (bus.inst_addr_ok) begin
                    state_n  = S_WAIT;
                    pc_n     = br_taken ? br_target : pc + 32'd4;
                    cancel_n = br_taken;
                end else if (br_taken) begin
                    pc_n = br_target;
                end
            end
            S_WAIT: begin
                if (br_taken) begin
                    pc_n     = br_target;
                    cancel_n = 1'b1;
                end
                if (bus.inst_data_ok) begin
                    state_n  = (cancel | br_taken) ? S_REQ : S_HOLD;
                    load     = ~(cancel | br_taken);
                    cancel_n = 1'b0;
                end
            end
            S_HOLD: begin
                if (br_taken) begin
                    state_n = S_REQ;
                    pc_n    = br_target;
                end else if (bus.ds_allowin) begin
                    state_n = S_REQ;
                end
            end
            default: state_n = S_REQ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            req_pc  <= 32'h0;
            cancel  <= 1'b0;
            fs_pc   <= 32'h0;
            fs_inst <= 32'h0000_0013;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            cancel <= cancel_n;
            if (state == S_REQ && bus.inst_addr_ok) req_pc <= pc;
            if (load) begin
                fs_pc   <= req_pc;
                fs_inst <= bus.inst_rdata;
            end
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: cycle-table stimulus for if_stage with a scoreboard of expected fetch bundles
module tb_if_stage;
    typedef struct {
        logic        r, b;
        logic [31:0] t;
        logic        a, ao, d;
        logic [31:0] rd;
        logic        keep, rst_chk, e_req;
        logic [31:0] e_addr;
        logic        e_valid;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [63:0] sb[$];
    logic [31:0] acc_addr = 32'h0;
    vec_t tbl[$];

    if_stage_if bus();
    if_stage #(.RESET_PC(32'h8000_0000)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic b, logic [31:0] t, logic a, logic ao, logic d,
                                logic [31:0] rd, logic keep, logic rst_chk, logic e_req,
                                logic [31:0] e_addr, logic e_valid);
        vec_t v;
        v.r = r; v.b = b; v.t = t; v.a = a; v.ao = ao; v.d = d; v.rd = rd;
        v.keep = keep; v.rst_chk = rst_chk; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        reset                = v.r;
        bus.branch_data      = {v.b, v.t};
        bus.ds_allowin       = v.a;
        bus.inst_addr_ok     = v.ao;
        bus.inst_data_ok     = v.d;
        bus.inst_rdata       = v.rd;
        #1;
        chk($sformatf("inst_req[%0d]", idx), {63'h0, bus.inst_req}, {63'h0, v.e_req});
        if (v.e_req) chk($sformatf("inst_addr[%0d]", idx), {32'h0, bus.inst_addr}, {32'h0, v.e_addr});
        chk($sformatf("fs_valid[%0d]", idx), {63'h0, bus.fs_valid}, {63'h0, v.e_valid});
        if (v.rst_chk) chk($sformatf("fs_data_reset[%0d]", idx), bus.fs_data, 64'h0000_0000_0000_0013);
        if (v.e_valid) begin
            if (sb.size() == 0) chk($sformatf("sb_empty_on_valid[%0d]", idx), 64'h1, 64'h0);
            else begin
                chk($sformatf("fs_data[%0d]", idx), bus.fs_data, sb[0]);
                if (v.a && !v.b) void'(sb.pop_front());
            end
        end
        if (v.ao && v.e_req) acc_addr = v.e_addr;
        if (v.d && v.keep) sb.push_back({acc_addr, v.rd});
    endtask

    localparam logic [31:0] B = 32'h8000_0000;
    localparam logic [31:0] X = 32'hDEAD_BEEF;

    initial begin
        bus.branch_data = '0; bus.ds_allowin = 1'b0; bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
        //               r  b  t             a  ao d  rd            kp rc rq addr            vld
        tbl.push_back(mk(1, 0, 0,            0, 0, 0, 0,            0, 0, 0, 0,            0));
        tbl.push_back(mk(0, 0, 0,            0, 1, 0, 0,            0, 1, 1, B,            0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 1, 32'h1111_0001,1, 0, 0, 0,            0));
        tbl.push_back(mk(0, 0, 0,            1, 0, 0, 0,            0, 0, 0, 0,            1));
        tbl.push_back(mk(0, 0, 0,            1, 1, 0, 0,            0, 0, 1, B+4,          0));
        tbl.push_back(mk(0, 0, 0,            1, 0, 1, 32'h1111_0002,1, 0, 0, 0,            0));
        tbl.push_back(mk(0, 0, 0,            1, 0, 0, 0,            0, 0, 0, 0,            1));
        tbl.push_back(mk(0, 0, 0,            1, 1, 0, 0,            0, 0, 1, B+8,          0));
        tbl.push_back(mk(0, 0, 0,            1, 0, 1, 32'h1111_0003,1, 0, 0, 0,            0));
        tbl.push_back(mk(0, 0, 0,            1, 0, 0, 0,            0, 0, 0, 0,            1));
        tbl.push_back(mk(0, 0, 0,            0, 1, 0, 0,            0, 0, 1, B+12,         0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 1, 32'h1111_0004,1, 0, 0, 0,            0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 0,        0, 0, 0, 0,            0, 0, 0, 0,            1));
        tbl.push_back(mk(0, 0, 0,            1, 0, 0, 0,            0, 0, 0, 0,            1));
        tbl.push_back(mk(0, 0, 0,            0, 1, 0, 0,            0, 0, 1, B+16,         0));
        tbl.push_back(mk(0, 1, B+32'h100,    0, 0, 0, 0,            0, 0, 0, 0,            0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 0,            0));
        tbl.push_back(mk(0, 0, 0,            1, 0, 1, X,            0, 0, 0, 0,            0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,            0, 0, 1, B+32'h100,    0));
        tbl.push_back(mk(0, 0, 0,            0, 1, 0, 0,            0, 0, 1, B+32'h100,    0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 1, 32'h1111_0005,1, 0, 0, 0,            0));
        tbl.push_back(mk(0, 0, 0,            1, 0, 0, 0,            0, 0, 0, 0,            1));
        tbl.push_back(mk(0, 1, B+8,          0, 0, 0, 0,            0, 0, 1, B+32'h104,    0));
        tbl.push_back(mk(0, 1, B+32'h203,    0, 1, 0, 0,            0, 0, 1, B+8,          0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 1, X,            0, 0, 0, 0,            0));
        tbl.push_back(mk(0, 0, 0,            0, 1, 0, 0,            0, 0, 1, B+32'h200,    0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 1, 32'h1111_0006,0, 0, 0, 0,            0));
        tbl.push_back(mk(0, 1, B+32'h300,    1, 0, 0, 0,            0, 0, 0, 0,            0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,            0, 0, 1, B+32'h300,    0));
        tbl.push_back(mk(0, 0, 0,            0, 1, 0, 0,            0, 0, 1, B+32'h300,    0));
        tbl.push_back(mk(1, 0, 0,            0, 0, 0, 0,            0, 0, 0, 0,            0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 1, X,            0, 1, 1, B,            0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,            0, 1, 1, B,            0));
        tbl.push_back(mk(0, 1, 32'hFFFF_FFFC,0, 0, 0, 0,            0, 0, 1, B,            0));
        tbl.push_back(mk(0, 0, 0,            0, 1, 0, 0,            0, 0, 1, 32'hFFFF_FFFC,0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 1, 32'h1111_0007,1, 0, 0, 0,            0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 1, X,            0, 0, 0, 0,            1));
        tbl.push_back(mk(0, 0, 0,            1, 0, 0, 0,            0, 0, 0, 0,            1));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 32'h0,        0));
        foreach (tbl[i]) apply(i, tbl[i]);
        // reset while a bundle is held: drop it and restart from the reset vector
        apply(100, mk(0, 0, 0, 0, 1, 0, 0,             0, 0, 1, 32'h0, 0));
        apply(101, mk(0, 0, 0, 0, 0, 1, 32'h2222_0001, 1, 0, 0, 0,     0));
        apply(102, mk(1, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0,     0));
        sb.delete();
        apply(103, mk(0, 0, 0, 0, 0, 0, 0,             0, 1, 1, B,     0));
        apply(104, mk(0, 0, 0, 0, 1, 0, 0,             0, 0, 1, B,     0));
        apply(105, mk(0, 0, 0, 0, 0, 1, 32'h2222_0002, 1, 0, 0, 0,     0));
        apply(106, mk(0, 0, 0, 1, 0, 0, 0,             0, 0, 0, 0,     1));
        apply(107, mk(0, 0, 0, 0, 0, 0, 0,             0, 0, 1, B+4,   0));
        chk("sb_drained", {32'h0, sb.size()}, 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
